conv1_kernel_fetch_ctrl: RTL and testbench

Sequencer for the conv1 kernel-weight ROM: on a start request it walks one selected kernel's KSIZE weights through the ROM's two read ports, two weights per beat. It streams the weights to the conv1 MAC array over a valid/ready interface. The controller owns both ROM address ports and absorbs the ROM's fixed 1-cycle read latency with a 2-entry skid FIFO, so the MAC array can apply backpressure without losing data.

---
 rtl/conv1_kernel_fetch_ctrl_if.sv | 31 +++
 rtl/conv1_kernel_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_conv1_kernel_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_kernel_fetch_ctrl_if.sv
// Weight-ROM read ports and the valid/ready weight-pair stream of the conv1 kernel fetcher.
// master = fetch controller, slave = ROM plus MAC-array consumer.
interface conv1_kernel_fetch_ctrl_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] rom_address_a;
   logic [ADDR_W-1:0] rom_address_b;
   logic [DATA_W-1:0] rom_q_a;
   logic [DATA_W-1:0] rom_q_b;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic              w_b_valid;
   logic              w_valid;
   logic              w_ready;
   logic              w_last;

   modport master (
      output rom_address_a, rom_address_b,
      input  rom_q_a, rom_q_b,
      output w_a, w_b, w_b_valid, w_valid, w_last,
      input  w_ready
   );

   modport slave (
      input  rom_address_a, rom_address_b,
      output rom_q_a, rom_q_b,
      input  w_a, w_b, w_b_valid, w_valid, w_last,
      output w_ready
   );
endinterface

// File: rtl/conv1_kernel_fetch_ctrl.sv
// Walks one kernel's weights through the dual-port ROM, two per beat, and streams them
// out through a 2-entry skid FIFO that absorbs the ROM's 1-cycle read latency.
module conv1_kernel_fetch_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   parameter int KSIZE  = 25,
   parameter int NUM_K  = 5
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic [2:0]                       kernel_idx,
   conv1_kernel_fetch_ctrl_if.master        bus,
   output logic                             busy,
   output logic                             done,
   output logic                             err
);
   localparam int NBEATS    = (KSIZE + 1) / 2;
   localparam int CNT_W     = $clog2(NBEATS + 1);
   localparam bit KSIZE_ODD = (KSIZE % 2) == 1;
   localparam logic [ADDR_W-1:0] KSIZE_A = ADDR_W'(KSIZE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              b_valid;
      logic              last;
   } beat_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  cnt;
   logic              q_valid;
   logic              q_last;
   logic              q_b_valid;
   beat_t             fifo_mem [2];
   beat_t             push_beat;
   beat_t             head;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic [2:0]        occupancy;
   logic              w_valid;
   logic              pop;
   logic              issue;
   logic              final_beat;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;

   assign w_valid    = fifo_count != 2'd0;
   assign pop        = w_valid & bus.w_ready;
   assign final_beat = cnt == CNT_W'(NBEATS - 1);

   // Pop is combinational so issue resumes in the same cycle the consumer frees a slot.
   assign occupancy = 3'(fifo_count) + 3'(q_valid) - 3'(pop);
   assign issue     = (state == RUN) && (cnt < CNT_W'(NBEATS)) && (occupancy < 3'd2);

   // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      addr_a = '0;
      addr_b = '0;
      if (state == RUN) begin
         addr_a = base + ADDR_W'({cnt, 1'b0});
         addr_b = (final_beat && KSIZE_ODD) ? addr_a : addr_a + ADDR_W'(1);
      end
   end

   assign bus.rom_address_a = addr_a;
   assign bus.rom_address_b = addr_b;

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         base  <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (int'(kernel_idx) >= NUM_K) begin
                     err <= 1'b1;
                  end else begin
                     base  <= ADDR_W'(kernel_idx) * KSIZE_A;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  cnt <= cnt + CNT_W'(1);
                  if (final_beat) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && head.last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tags travel alongside the ROM read so the beat is complete when the data lands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_valid   <= 1'b0;
         q_last    <= 1'b0;
         q_b_valid <= 1'b0;
      end else begin
         q_valid   <= issue;
         q_last    <= issue && final_beat;
         q_b_valid <= !(final_beat && KSIZE_ODD);
      end
   end

   assign push_beat.a       = bus.rom_q_a;
   assign push_beat.b       = q_b_valid ? bus.rom_q_b : '0;
   assign push_beat.b_valid = q_b_valid;
   assign push_beat.last    = q_last;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (q_valid) wr_ptr <= ~wr_ptr;
         if (pop)     rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + 2'(q_valid) - 2'(pop);
      end
   end

   // NOTE: FIFO storage is not reset; its outputs are gated by w_valid, so stale contents never escape.
   always_ff @(posedge clock) begin
      if (q_valid) fifo_mem[wr_ptr] <= push_beat;
   end

   assign head          = fifo_mem[rd_ptr];
   assign bus.w_valid   = w_valid;
   assign bus.w_a       = w_valid ? head.a : '0;
   assign bus.w_b       = w_valid ? head.b : '0;
   assign bus.w_b_valid = w_valid && head.b_valid;
   assign bus.w_last    = w_valid && head.last;
endmodule

// File: tb/tb_conv1_kernel_fetch_ctrl.sv
// Directed-sequence bench for conv1_kernel_fetch_ctrl with a random ROM image and a
// beat-list reference model built from the kernel layout rules.
module tb_conv1_kernel_fetch_ctrl;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;
   localparam int KSIZE  = 25;
   localparam int NUM_K  = 5;
   localparam int NBEATS = (KSIZE + 1) / 2;
   localparam int BUDGET = 80;

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              bv;
      logic              last;
   } beat_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              start = 1'b0;
   logic [2:0]        kernel_idx = 3'd0;
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] rom [2**ADDR_W];
   beat_t             exp_q [$];
   int                n_cmp = 0;
   int                n_fail = 0;
   int                fv;
   int                dc;

   conv1_kernel_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   conv1_kernel_fetch_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .KSIZE(KSIZE), .NUM_K(NUM_K)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .kernel_idx (kernel_idx),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   // Synchronous ROM with 1-cycle read latency on both ports.
   always @(posedge clock) begin
      bus.rom_q_a <= rom[bus.rom_address_a];
      bus.rom_q_b <= rom[bus.rom_address_b];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_w_valid"}, 32'(bus.w_valid), 0);
      check({tag, "_w_a"}, 32'(bus.w_a), 0);
      check({tag, "_w_b"}, 32'(bus.w_b), 0);
      check({tag, "_w_b_valid"}, 32'(bus.w_b_valid), 0);
      check({tag, "_w_last"}, 32'(bus.w_last), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_addr_a"}, 32'(bus.rom_address_a), 0);
      check({tag, "_addr_b"}, 32'(bus.rom_address_b), 0);
   endtask

   task automatic launch(input int k);
      @(negedge clock);
      start      = 1'b1;
      kernel_idx = 3'(k);
   endtask

   // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: ready low for cycles 1..20.
   task automatic run(input int k, input int mode, input bit poke, input int abort_at,
                      input int chain_k, output int first_valid, output int done_cyc);
      int          delivered = 0;
      bit          prev_stall = 1'b0;
      logic [33:0] prev_out = '0;
      bit          tog [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int          base = k * KSIZE;
      exp_q.delete();
      for (int j = 0; j < NBEATS; j++) begin
         beat_t b;
         int idx = base + 2 * j;
         b.a = rom[idx];
         if (2 * j + 1 < KSIZE) begin
            b.b  = rom[idx + 1];
            b.bv = 1'b1;
         end else begin
            b.b  = '0;
            b.bv = 1'b0;
         end
         b.last = (j == NBEATS - 1);
         exp_q.push_back(b);
      end
      first_valid = -1;
      done_cyc    = -1;
      @(posedge clock);
      #1;
      start      = 1'b0;
      kernel_idx = 3'($urandom_range(0, 7));
      for (int cyc = 1; cyc <= BUDGET; cyc++) begin
         logic [33:0] cur;
         int          issued;
         @(negedge clock);
         start = 1'b0;
         case (mode)
            0:       bus.w_ready = 1'b1;
            1:       bus.w_ready = tog[cyc % 4];
            default: bus.w_ready = (cyc > 20);
         endcase
         if (poke && cyc == 5) begin
            start      = 1'b1;
            kernel_idx = 3'((k == 0) ? 1 : 0);
         end
         #1;
         cur = {bus.w_last, bus.w_b_valid, bus.w_b, bus.w_a};
         if (prev_stall) begin
            check("stall_valid", 32'(bus.w_valid), 1);
            check("stall_hold", 32'(cur == prev_out), 1);
         end
         prev_stall = bus.w_valid && !bus.w_ready;
         prev_out   = cur;
         if (bus.w_valid && first_valid < 0) first_valid = cyc;
         if (mode == 0 && abort_at == 0 && cyc <= NBEATS) begin
            check("addr_a", 32'(bus.rom_address_a), 32'(base + 2 * (cyc - 1)));
            check("addr_b", 32'(bus.rom_address_b),
                  32'((cyc == NBEATS) ? base + 2 * (cyc - 1) : base + 2 * (cyc - 1) + 1));
         end
         if (k != 0 && bus.rom_address_a != '0) begin
            issued = (int'(bus.rom_address_a) - base) / 2;
            check("inflight_le2", 32'(issued - delivered <= 2), 1);
         end
         if (mode == 2 && cyc == 20) begin
            check("stall_addr", 32'(bus.rom_address_a), 32'(base + 4));
            check("stall_head", 32'(bus.w_a), 32'(rom[base]));
         end
         if (abort_at == cyc) begin
            reset = 1'b1;
            #1;
            check_zero("abort");
            @(negedge clock);
            reset = 1'b0;
            exp_q.delete();
            return;
         end
         if (bus.w_valid && bus.w_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 32'(exp_q.size()), 1);
            end else begin
               beat_t e = exp_q.pop_front();
               check("beat_a", 32'(bus.w_a), 32'(e.a));
               check("beat_b", 32'(bus.w_b), 32'(e.b));
               check("beat_b_valid", 32'(bus.w_b_valid), 32'(e.bv));
               check("beat_last", 32'(bus.w_last), 32'(e.last));
            end
            delivered++;
         end
         if (done) begin
            done_cyc = cyc;
            check("drained", 32'(exp_q.size()), 0);
            if (chain_k >= 0) begin
               start      = 1'b1;
               kernel_idx = 3'(chain_k);
            end
            return;
         end
      end
   endtask

   initial begin
      foreach (rom[i]) rom[i] = 16'($urandom);
      bus.w_ready = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Kernel 0, ready high: timing, addresses, data.
      launch(0);
      run(0, 0, 1'b0, 0, -1, fv, dc);
      check("k0_first_valid", 32'(fv), 3);
      check("k0_done_cycle", 32'(dc), 16);

      // Kernel 4 with ready toggling 1,0,0,1.
      launch(4);
      run(4, 1, 1'b0, 0, -1, fv, dc);
      check("k4_done_seen", 32'(dc > 0), 1);

      // Kernel 2 with a 20-cycle stall, then contiguous delivery.
      launch(2);
      run(2, 2, 1'b0, 0, -1, fv, dc);
      check("k2_first_valid", 32'(fv), 3);
      check("k2_done_cycle", 32'(dc), 34);

      // Illegal kernel indices.
      for (int n = 0; n < 2; n++) begin
         launch(n == 0 ? 5 : 7);
         @(posedge clock);
         #1;
         start = 1'b0;
         @(negedge clock);
         check("bad_err", 32'(err), 1);
         check("bad_busy", 32'(busy), 0);
         check("bad_addr_a", 32'(bus.rom_address_a), 0);
         check("bad_addr_b", 32'(bus.rom_address_b), 0);
         @(negedge clock);
         check("bad_err_pulse", 32'(err), 0);
      end

      // Start during RUN is ignored; start in the done cycle is accepted.
      launch(3);
      run(3, 0, 1'b1, 0, 1, fv, dc);
      check("k3_done_cycle", 32'(dc), 16);
      run(1, 0, 1'b0, 0, -1, fv, dc);
      check("chain_first_valid", 32'(fv), 3);
      check("chain_done_cycle", 32'(dc), 16);

      // Reset in cycle 8 of a fetch, then a clean fetch of kernel 1.
      launch(2);
      run(2, 0, 1'b0, 8, -1, fv, dc);
      launch(1);
      run(1, 0, 1'b0, 0, -1, fv, dc);
      check("post_reset_first_valid", 32'(fv), 3);
      check("post_reset_done_cycle", 32'(dc), 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
